// File: rtl/exec_pkg.sv
// Shared definitions for the execution sequencer: state encodings, widths
// and the saturating instruction-counter increment.
package exec_pkg;

  localparam int STATE_W = 2;
  localparam int CNT_W   = 16;

  typedef enum logic [STATE_W-1:0] {
    ST_HALT  = 2'b00,
    ST_RUN   = 2'b01,
    ST_STEP  = 2'b10,
    ST_BREAK = 2'b11
  } state_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] r;
    if (v == {CNT_W{1'b1}}) begin
      r = v;
    end else begin
      r = v + CNT_W'(1);
    end
    return r;
  endfunction

endpackage

// File: rtl/exec_ctrl_if.sv
// Board/core side bundle of the execution sequencer. The slave modport is
// the sequencer's view; the master modport is the board/core view.
interface exec_ctrl_if;
  import exec_pkg::*;

  logic                run_sw;
  logic                step_btn;
  logic                cont_btn;
  logic                bp_en;
  logic [31:0]         bp_addr;
  logic [31:0]         pc;
  logic                cpu_en;
  logic [STATE_W-1:0]  state;
  logic                halted;
  logic [CNT_W-1:0]    instr_cnt;

  modport slave (
    input  run_sw, step_btn, cont_btn, bp_en, bp_addr, pc,
    output cpu_en, state, halted, instr_cnt
  );

  modport master (
    output run_sw, step_btn, cont_btn, bp_en, bp_addr, pc,
    input  cpu_en, state, halted, instr_cnt
  );
endinterface

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer, level debouncer that needs
// DEB_CYCLES consecutive samples of a new level, and a one-cycle pulse on
// each debounced press (holding the button yields a single pulse).
module btn_debounce #(
  parameter int DEB_CYCLES = 500_000,
  parameter int DEB_W      = 19
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic pulse
);

  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
  localparam logic [DEB_W-1:0] DEB_ONE  = DEB_W'(1);

  logic             sync1_r;
  logic             sync2_r;
  logic             level_r;
  logic             pulse_r;
  logic [DEB_W-1:0] cnt_r;
  logic             change_s;
  logic             settle_s;

  // Detect a differing sample and the sample that completes the stable run.
  always_comb begin
    change_s = (sync2_r != level_r);
    settle_s = change_s && (cnt_r == DEB_LAST);
  end

  // Bring the raw button into the clk domain.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= btn_raw;
      sync2_r <= sync1_r;
    end
  end

  // Count consecutive samples of the new level; accept it and pulse on a press.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      level_r <= 1'b0;
      cnt_r   <= '0;
      pulse_r <= 1'b0;
    end else begin
      pulse_r <= 1'b0;
      if (settle_s) begin
        level_r <= sync2_r;
        cnt_r   <= '0;
        pulse_r <= sync2_r;
      end else if (change_s) begin
        cnt_r <= cnt_r + DEB_ONE;
      end else begin
        cnt_r <= '0;
      end
    end
  end

  assign pulse = pulse_r;

endmodule

// File: rtl/exec_ctrl.sv
// Execution sequencer for the single-cycle MIPS core: turns switches and
// buttons into a one-cycle clock enable (halt / run / single-step / break),
// and counts issued instructions for the display.
module exec_ctrl
  import exec_pkg::*;
#(
  parameter int RUN_DIV    = 50_000_000,
  parameter int DIV_W      = 26,
  parameter int DEB_CYCLES = 500_000,
  parameter int DEB_W      = 19
) (
  input  logic       clk,
  input  logic       reset,
  exec_ctrl_if.slave bus
);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

  state_t            state_r;
  logic [DIV_W-1:0]  div_r;
  logic              cpu_en_r;
  logic              bp_skip_r;
  logic [CNT_W-1:0]  instr_cnt_r;
  logic              step_p;
  logic              cont_p;
  logic              div_tc_s;
  logic              bp_hit_s;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES), .DEB_W(DEB_W)) u_step_deb (
    .clk     (clk),
    .reset   (reset),
    .btn_raw (bus.step_btn),
    .pulse   (step_p)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES), .DEB_W(DEB_W)) u_cont_deb (
    .clk     (clk),
    .reset   (reset),
    .btn_raw (bus.cont_btn),
    .pulse   (cont_p)
  );

  // Terminal count of the run prescaler and an armed breakpoint match.
  always_comb begin
    div_tc_s = (div_r == DIV_LAST);
    bp_hit_s = bus.bp_en && (bus.pc == bus.bp_addr) && !bp_skip_r;
  end

  // Sequencer FSM; the prescaler only counts in RUN and sits at zero elsewhere,
  // so every entry into RUN starts a full RUN_DIV period.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= ST_HALT;
      div_r     <= '0;
      cpu_en_r  <= 1'b0;
      bp_skip_r <= 1'b0;
    end else begin
      cpu_en_r <= 1'b0;
      case (state_r)
        ST_HALT: begin
          div_r <= '0;
          if (bus.run_sw) begin
            state_r <= ST_RUN;
          end else if (step_p) begin
            state_r  <= ST_STEP;
            cpu_en_r <= 1'b1;
          end else begin
            state_r <= ST_HALT;
          end
        end
        ST_STEP: begin
          div_r   <= '0;
          state_r <= ST_HALT;
        end
        ST_RUN: begin
          if (!bus.run_sw) begin
            state_r <= ST_HALT;
            div_r   <= '0;
          end else if (div_tc_s) begin
            div_r <= '0;
            if (bp_hit_s) begin
              state_r <= ST_BREAK;
            end else begin
              cpu_en_r  <= 1'b1;
              bp_skip_r <= 1'b0;
            end
          end else begin
            div_r <= div_r + DIV_ONE;
          end
        end
        ST_BREAK: begin
          div_r <= '0;
          if (!bus.run_sw) begin
            state_r <= ST_HALT;
          end else if (cont_p) begin
            state_r   <= ST_RUN;
            bp_skip_r <= 1'b1;
          end else if (step_p) begin
            state_r  <= ST_STEP;
            cpu_en_r <= 1'b1;
          end else begin
            state_r <= ST_BREAK;
          end
        end
        default: begin
          state_r <= ST_HALT;
          div_r   <= '0;
        end
      endcase
    end
  end

  // Count issued instructions, saturating at all-ones.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr_cnt_r <= '0;
    end else if (cpu_en_r) begin
      instr_cnt_r <= sat_inc(instr_cnt_r);
    end else begin
      instr_cnt_r <= instr_cnt_r;
    end
  end

  assign bus.cpu_en    = cpu_en_r;
  assign bus.state     = state_r;
  assign bus.halted    = (state_r == ST_HALT) || (state_r == ST_BREAK);
  assign bus.instr_cnt = instr_cnt_r;

endmodule

// File: doc/exec_ctrl.md
Name: exec_ctrl

Overview:
- Execution sequencer for the single-cycle MIPS core on the prototyping board.
- Replaces the free-running divided clock with a one-cycle clock-enable (cpu_en) in the 50 MHz domain.
- Supports halt, free-run at a programmable rate, single-step from a push button, and halt on a PC breakpoint.
- Sits between board inputs (switches/buttons) and the core; exposes state and a retired-instruction count for the 7-seg display mux.

Parameters:
- RUN_DIV, 50_000_000: clk cycles between cpu_en pulses in RUN mode (1 Hz at 50 MHz); must be >= 2.
- DIV_W, 26: prescaler width; must satisfy 2^DIV_W >= RUN_DIV.
- DEB_CYCLES, 500_000: stable-level cycles required by the button debouncer (10 ms).
- DEB_W, 19: debounce counter width.

Ports:
- clk  in  1  50 MHz board clock; the only clock.
- reset  in  1  asynchronous, active-low reset.
- run_sw  in  1  level switch; 1 = run mode requested, 0 = halt.
- step_btn  in  1  raw asynchronous push button; each press retires one instruction while halted.
- cont_btn  in  1  raw asynchronous push button; resumes from BREAK.
- bp_en  in  1  breakpoint enable.
- bp_addr  in  32  breakpoint PC (byte address).
- pc  in  32  current core PC.
- cpu_en  out  1  one-cycle enable to the core; the core updates state only when cpu_en=1.
- state  out  2  HALT=00, RUN=01, STEP=10, BREAK=11.
- halted  out  1  1 when state is HALT or BREAK.
- instr_cnt  out  16  number of cpu_en pulses issued; saturates at 16'hFFFF.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=HALT, cpu_en=0, halted=1, instr_cnt=0.
  - Prescaler, debouncers and bp_skip cleared.
- Buttons (per button, in sub-module btn_debounce):
  - 2-flop synchronizer.
  - Debounced level changes only after the synchronized input has held a new level for DEB_CYCLES consecutive cycles.
  - Rising edge of the debounced level gives a one-cycle pulse (step_p, cont_p).
  - Holding a button gives exactly one pulse.
- cpu_en is registered and high for exactly one cycle per issue; never high on two consecutive cycles.
- HALT:
  - run_sw=1 → RUN. Prescaler cleared; first pulse is RUN_DIV cycles after entry.
  - Otherwise, step_p → STEP.
  - cont_p is ignored.
- STEP:
  - Assert cpu_en for one cycle, then → HALT.
  - Breakpoints are ignored in STEP.
- RUN:
  - run_sw=0 → HALT next cycle. Prescaler cleared; any pending pulse is dropped.
  - Prescaler counts 0..RUN_DIV-1. At terminal count:
    - If bp_en=1, pc==bp_addr and bp_skip=0 → BREAK, no cpu_en.
    - Else assert cpu_en and clear bp_skip.
  - step_p and cont_p are ignored.
- BREAK:
  - run_sw=0 → HALT.
  - Else cont_p → RUN with bp_skip=1 and prescaler cleared, so the breakpointed instruction executes once and a loop revisiting bp_addr breaks again.
  - step_p in BREAK → STEP (single-step past a breakpoint).
- Simultaneous events: run_sw=0 has priority over all buttons; in HALT, run_sw=1 has priority over step_p.
- instr_cnt increments on every cycle with cpu_en=1; it holds at FFFF.
- halted and state are combinational decodes of the state register.

Decomposition:
- Shared package exec_pkg:
  - State encodings (HALT/RUN/STEP/BREAK, 2 bits).
  - STATE_W=2, CNT_W=16.
- One sub-module, btn_debounce (params DEB_CYCLES, DEB_W; ports clk, reset, btn_raw, pulse), instantiated twice.
- FSM, prescaler and counter stay in exec_ctrl.

Test Plan (RUN_DIV=4, DEB_CYCLES=3):
- Reset with run_sw=0 → state=00, halted=1, cpu_en=0, instr_cnt=0. Assert reset mid-RUN → same values immediately, without waiting for a clock edge.
- HALT, step_btn held high 20 cycles with 1-cycle glitches before it → exactly one cpu_en pulse; state goes 00→10→00; instr_cnt=1.
- run_sw=1 for 17 cycles, bp_en=0 → cpu_en at cycles 4, 8, 12, 16 after entry; instr_cnt=4. Drop run_sw at cycle 14 → state=00 next cycle, no pulse at 16, instr_cnt=3.
- RUN with bp_en=1, bp_addr=32'h0000_0010, pc driven to 0x10 → state=11, halted=1, no cpu_en. Press cont_btn → RUN, one cpu_en at pc=0x10. pc returns to 0x10 later → BREAK again.
- BREAK with step_btn press → single cpu_en, state 11→10→00.
- Preload instr_cnt near FFFF via 65 540 RUN pulses → instr_cnt holds at FFFF with no wrap.
